// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM states,
// access-size decode and alignment helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    typedef logic [3:0] lsu_be_t;

    // Reserved encodings fall back to a full word access.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            F3_LB, F3_LBU: sz = SZ_BYTE;
            F3_LH, F3_LHU: sz = SZ_HALF;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(
        input lsu_size_e  sz,
        input logic [1:0] off
    );
        logic mis;
        case (sz)
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering shared by both directions of the LSU.
// Ports: funct3/offset select size and lane; wdata -> wdata_lane + be
//        (store path); rdata -> rdata_ext (load extract and extend).
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output lsu_be_t     be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    lsu_size_e   sz;
    logic        sext;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sz   = f3_size(funct3);
        sext = ~funct3[2];

        case (offset)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = offset[1] ? rdata[31:16] : rdata[15:0];

        case (sz)
            SZ_BYTE: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sext & b[7]}}, b};
            end
            SZ_HALF: begin
                be         = 4'b0011 << {offset[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sext & h[15]}}, h};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Data-memory access sequencer for the 3-stage core: one bus access per
// load/store, pipeline stall, misalignment and timeout detection.
// Ports: mem_read_i/mem_write_i/funct3_i/addr_i/wdata_i from execute;
//        stall_o, load_valid_o, load_data_o, misaligned_o, bus_err_o to
//        the pipeline; dbus_* is the valid/ready request + response bus.
import lsu_pkg::*;

module lsu_controller #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              load_valid_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              misaligned_o,
    output logic              bus_err_o,
    output logic              dbus_valid_o,
    input  logic              dbus_ready_i,
    output logic              dbus_we_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output logic [3:0]        dbus_be_o,
    output logic [DATA_W-1:0] dbus_wdata_o,
    input  logic              dbus_rsp_valid_i,
    input  logic [DATA_W-1:0] dbus_rdata_i
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    lsu_state_e state;
    logic [15:0] cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        err_q;

    logic        idle, req, mis, start;
    logic        rsp_done, timed_out;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    lsu_be_t     al_be;
    logic [31:0] al_wdata, al_rdata;

    // Reset also masks the request so every output reads 0 while held.
    assign idle  = (state == ST_IDLE);
    assign req   = (mem_read_i | mem_write_i) & ~rst;
    assign mis   = is_misaligned(f3_size(funct3_i), addr_i[1:0]);
    assign start = idle & req & ~mis;

    // One aligner: fed by the live request in IDLE, by the latched
    // access while the bus transaction is in flight.
    assign al_f3  = idle ? funct3_i    : f3_q;
    assign al_off = idle ? addr_i[1:0] : off_q;

    lsu_align u_align (
        .funct3     (al_f3),
        .offset     (al_off),
        .wdata      (wdata_i),
        .rdata      (dbus_rdata_i),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata)
    );

    assign rsp_done = dbus_rsp_valid_i &
                      ((state == ST_REQ & dbus_ready_i) |
                       (state == ST_WAIT_RSP));
    // A response in the final allowed cycle still wins over the timeout.
    assign timed_out = (state == ST_REQ | state == ST_WAIT_RSP) &
                       ~rsp_done & (cnt == CNT_LAST);

    assign stall_o      = start | state == ST_REQ | state == ST_WAIT_RSP;
    assign misaligned_o = idle & req & mis;
    assign dbus_valid_o = (state == ST_REQ);
    assign load_valid_o = (state == ST_DONE) & ~dbus_we_o & ~err_q;
    assign bus_err_o    = (state == ST_DONE) & err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            f3_q         <= '0;
            off_q        <= '0;
            err_q        <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= '0;
            dbus_wdata_o <= '0;
            load_data_o  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        dbus_we_o    <= mem_write_i;
                        f3_q         <= funct3_i;
                        off_q        <= addr_i[1:0];
                        dbus_be_o    <= al_be;
                        dbus_wdata_o <= al_wdata;
                        dbus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                        cnt          <= '0;
                        err_q        <= 1'b0;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ, ST_WAIT_RSP: begin
                    if (rsp_done) begin
                        if (!dbus_we_o) load_data_o <= al_rdata;
                        state <= ST_DONE;
                    end else if (timed_out) begin
                        err_q       <= 1'b1;
                        load_data_o <= '0;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (state == ST_REQ && dbus_ready_i)
                            state <= ST_WAIT_RSP;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: directed plan cases, random
// accesses against a byte-lane reference model, timeout and reset.
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, ready, rsp_valid;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;

    logic        stall_o, load_valid_o, misaligned_o, bus_err_o;
    logic        dbus_valid_o, dbus_we_o;
    logic [31:0] load_data_o, dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;

    logic        t_stall, t_load_valid, t_mis, t_bus_err, t_valid, t_we;
    logic [31:0] t_load_data, t_addr, t_wdata;
    logic [3:0]  t_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_controller #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst),
        .mem_read_i(mem_read), .mem_write_i(mem_write),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall_o), .load_valid_o(load_valid_o),
        .load_data_o(load_data_o), .misaligned_o(misaligned_o),
        .bus_err_o(bus_err_o), .dbus_valid_o(dbus_valid_o),
        .dbus_ready_i(ready), .dbus_we_o(dbus_we_o),
        .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_rsp_valid_i(rsp_valid),
        .dbus_rdata_i(rdata)
    );

    lsu_controller #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst),
        .mem_read_i(mem_read), .mem_write_i(mem_write),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .stall_o(t_stall), .load_valid_o(t_load_valid),
        .load_data_o(t_load_data), .misaligned_o(t_mis),
        .bus_err_o(t_bus_err), .dbus_valid_o(t_valid),
        .dbus_ready_i(ready), .dbus_we_o(t_we),
        .dbus_addr_o(t_addr), .dbus_be_o(t_be),
        .dbus_wdata_o(t_wdata), .dbus_rsp_valid_i(rsp_valid),
        .dbus_rdata_i(rdata)
    );

    // Reference model: access width in bytes, straight from funct3.
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
        int mask;
        mask = (1 << sz) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] w);
        if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int sz,
                                           input logic [31:0] a,
                                           input logic [31:0] d);
        logic [31:0] v, mask, top;
        if (sz == 4) return d;
        mask = (sz == 1) ? 32'hFF : 32'hFFFF;
        top  = (sz == 1) ? 32'h80 : 32'h8000;
        v = (d >> (8 * (a % 4))) & mask;
        if (f3[2] == 1'b0 && (v & top) != 0) v = v | ~mask;
        return v;
    endfunction

    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] w,
                             input int rdly, input int gap,
                             input logic [31:0] rdv, input string nm);
        int sz, nst, exp_st;
        bit mis;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld, eaddr;
        sz    = m_size(f3);
        mis   = (a % sz) != 0;
        ebe   = m_be(sz, a);
        ewd   = m_wdata(sz, w);
        eld   = m_load(f3, sz, a, rdv);
        eaddr = a & 32'hFFFF_FFFC;

        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = w;
        ready = 1'b0; rsp_valid = 1'b0;
        #1;
        if (mis) begin
            checks++;
            if (misaligned_o !== 1'b1 || stall_o !== 1'b0 || dbus_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL %s misaligned: mis=%b stall=%b valid=%b want 1 0 0",
                         nm, misaligned_o, stall_o, dbus_valid_o);
            end
            @(negedge clk);
            mem_read = 1'b0; mem_write = 1'b0;
            #1;
            checks++;
            if (misaligned_o !== 1'b0 || stall_o !== 1'b0 || dbus_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL %s mis_after: mis=%b stall=%b valid=%b want 0 0 0",
                         nm, misaligned_o, stall_o, dbus_valid_o);
            end
            return;
        end

        checks++;
        if (stall_o !== 1'b1 || misaligned_o !== 1'b0 || dbus_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s issue: stall=%b mis=%b valid=%b want 1 0 0",
                     nm, stall_o, misaligned_o, dbus_valid_o);
        end
        nst = (stall_o === 1'b1) ? 1 : 0;

        for (int k = 0; k <= rdly; k++) begin
            @(negedge clk);
            rdata = $urandom;
            if (k == rdly) begin
                ready = 1'b1;
                if (gap == 0) begin rsp_valid = 1'b1; rdata = rdv; end
            end
            #1;
            checks++;
            if (dbus_valid_o !== 1'b1 || dbus_addr_o !== eaddr ||
                dbus_be_o !== ebe || dbus_we_o !== wr ||
                (wr && dbus_wdata_o !== ewd)) begin
                errors++;
                $display("FAIL %s req%0d: valid=%b addr=%h be=%b we=%b wd=%h want 1 %h %b %b %h",
                         nm, k, dbus_valid_o, dbus_addr_o, dbus_be_o, dbus_we_o,
                         dbus_wdata_o, eaddr, ebe, wr, ewd);
            end
            if (stall_o === 1'b1) nst++;
        end

        for (int k = 1; k <= gap; k++) begin
            @(negedge clk);
            ready = 1'b0; rsp_valid = 1'b0; rdata = $urandom;
            if (k == gap) begin rsp_valid = 1'b1; rdata = rdv; end
            #1;
            checks++;
            if (dbus_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL %s wait%0d: valid=%b want 0", nm, k, dbus_valid_o);
            end
            if (stall_o === 1'b1) nst++;
        end

        @(negedge clk);
        ready = 1'b0; rsp_valid = 1'b0; rdata = $urandom;
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        exp_st = 2 + rdly + gap;
        checks++;
        if (nst != exp_st) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d want %0d", nm, nst, exp_st);
        end
        checks++;
        if (stall_o !== 1'b0 || load_valid_o !== !wr || bus_err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s done: stall=%b lv=%b err=%b want 0 %b 0",
                     nm, stall_o, load_valid_o, bus_err_o, !wr);
        end
        if (!wr) begin
            checks++;
            if (load_data_o !== eld) begin
                errors++;
                $display("FAIL %s load_data: got %h want %h", nm, load_data_o, eld);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (load_valid_o !== 1'b0 || stall_o !== 1'b0 || dbus_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: lv=%b stall=%b valid=%b want 0 0 0",
                     nm, load_valid_o, stall_o, dbus_valid_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0; addr = '0;
        wdata = '0; ready = 1'b0; rsp_valid = 1'b0; rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({stall_o, load_valid_o, misaligned_o, bus_err_o, dbus_valid_o,
             dbus_we_o} !== 6'b0 || load_data_o !== '0 || dbus_addr_o !== '0 ||
            dbus_be_o !== '0 || dbus_wdata_o !== '0) begin
            errors++;
            $display("FAIL reset_state: flags=%b ld=%h addr=%h be=%b wd=%h want all 0",
                     {stall_o, load_valid_o, misaligned_o, bus_err_o, dbus_valid_o,
                      dbus_we_o}, load_data_o, dbus_addr_o, dbus_be_o, dbus_wdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0, "sw_basic");
        do_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF_0000, "lb_sext");
        do_access(1, 0, 3'b101, 32'h102, 32'h0, 0, 1, 32'hBEEF_1234, "lhu_zext");
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h0, "lw_misaligned");
        do_access(0, 1, 3'b001, 32'h2, 32'h1234_5678, 5, 1, 32'h0, "sh_ready_wait");
        do_access(1, 0, 3'b010, 32'h40, 32'h0, 0, 0, 32'hCAFE_F00D, "lw_min_latency");
        do_access(1, 1, 3'b000, 32'h41, 32'hA5, 1, 2, 32'h0, "both_is_write");
        do_access(1, 0, 3'b111, 32'h44, 32'h0, 0, 1, 32'h8765_4321, "undef_f3_lw");
    endtask

    task automatic test_rsp_ignored();
        @(negedge clk);
        rsp_valid = 1'b1; rdata = 32'h1111_2222;
        #1;
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        checks++;
        if (load_valid_o !== 1'b0 || stall_o !== 1'b0 || dbus_valid_o !== 1'b0 ||
            bus_err_o !== 1'b0) begin
            errors++;
            $display("FAIL rsp_in_idle: lv=%b stall=%b valid=%b err=%b want 0 0 0 0",
                     load_valid_o, stall_o, dbus_valid_o, bus_err_o);
        end
    endtask

    task automatic test_random();
        logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 40; i++) begin
            int op, sz;
            logic [2:0]  f3;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            if (op == 0) f3 = ld_f3[$urandom_range(0, 7)];
            else         f3 = st_f3[$urandom_range(0, 5)];
            sz = m_size(f3);
            a  = $urandom;
            if ($urandom_range(0, 9) < 7) a = a - (a % sz);
            do_access(op != 1, op != 0, f3, a, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                      $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_timeout();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h200;
        ready = 1'b0; rsp_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (t_valid !== 1'b1 || t_bus_err !== 1'b0 || t_stall !== 1'b1) begin
                errors++;
                $display("FAIL to_req%0d: valid=%b err=%b stall=%b want 1 0 1",
                         k, t_valid, t_bus_err, t_stall);
            end
        end
        @(negedge clk);
        mem_read = 1'b0;
        #1;
        checks++;
        if (t_bus_err !== 1'b1 || t_load_valid !== 1'b0 || t_stall !== 1'b0 ||
            t_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_err: err=%b lv=%b stall=%b valid=%b want 1 0 0 0",
                     t_bus_err, t_load_valid, t_stall, t_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (t_bus_err !== 1'b0 || t_stall !== 1'b0 || t_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: err=%b stall=%b valid=%b want 0 0 0",
                     t_bus_err, t_stall, t_valid);
        end

        // Reset in the middle of WAIT_RSP.
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b000; addr = 32'h201; ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ready = 1'b0;
        #1;
        checks++;
        if (t_stall !== 1'b1 || t_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre: stall=%b valid=%b want 1 0", t_stall, t_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({t_stall, t_valid, t_load_valid, t_bus_err, t_mis, t_we} !== 6'b0 ||
            t_be !== '0 || t_addr !== '0 || t_load_data !== '0 ||
            {stall_o, dbus_valid_o, load_valid_o} !== 3'b0) begin
            errors++;
            $display("FAIL rst_async: t=%b be=%b addr=%h dut=%b want all 0",
                     {t_stall, t_valid, t_load_valid, t_bus_err, t_mis, t_we},
                     t_be, t_addr, {stall_o, dbus_valid_o, load_valid_o});
        end
        @(negedge clk);
        mem_read = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (t_load_valid !== 1'b0 || t_bus_err !== 1'b0 || t_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_pulse: lv=%b err=%b valid=%b want 0 0 0",
                     t_load_valid, t_bus_err, t_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rsp_ignored();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
- Sequences every data-memory access issued by the execute stage of the 3-stage RISC-V core (loads when wb_sel selects memory, stores when mem_write is asserted) over a valid/ready data bus.
- Generates byte enables and lane-aligned write data, and sign- or zero-extends load data.
- Holds the pipeline stalled until the access completes.
- Detects misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, bus data width (fixed 32 for RV32I)
- TIMEOUT, 255, max cycles spent in REQ+WAIT_RSP before a bus error; valid range 1..65535

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_read_i  in  1  execute-stage load request (wb_sel==2'b01)
- mem_write_i  in  1  execute-stage store request
- funct3_i  in  3  access size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- addr_i  in  ADDR_W  byte address from ALU
- wdata_i  in  DATA_W  store data (rs2)
- stall_o  out  1  freeze PC/pipeline registers
- load_valid_o  out  1  one-cycle pulse: load_data_o valid
- load_data_o  out  DATA_W  extended load result
- misaligned_o  out  1  one-cycle pulse: misaligned access rejected
- bus_err_o  out  1  one-cycle pulse: timeout
- dbus_valid_o  out  1  request valid
- dbus_ready_i  in  1  request accepted
- dbus_we_o  out  1  1=write
- dbus_addr_o  out  ADDR_W  word-aligned address (addr[1:0]=0)
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  DATA_W  lane-replicated store data
- dbus_rsp_valid_i  in  1  response/ack (writes also acked)
- dbus_rdata_i  in  DATA_W  read data

Behaviour:
- Reset: state IDLE, counter 0, all outputs 0. Reset mid-access drops dbus_valid_o immediately; no completion pulse.
- States: IDLE, REQ, WAIT_RSP, DONE.
- Request = mem_read_i|mem_write_i; if both are high, treat as a write.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0. Byte is always aligned.
- IDLE, misaligned request: misaligned_o=1 that cycle, no bus access, stall_o=0, stay IDLE.
- IDLE, aligned request: latch we, funct3, addr[1:0], be, wdata, word address; go REQ. stall_o=1 combinationally that same cycle.
- REQ: dbus_valid_o=1 with stable payload until dbus_ready_i. On handshake go WAIT_RSP. If dbus_rsp_valid_i arrives in the same cycle as ready, go straight to DONE and capture data.
- WAIT_RSP: on dbus_rsp_valid_i capture rdata, go DONE.
- Counter: clears on entering REQ and increments in REQ and WAIT_RSP. When it reaches TIMEOUT without completion: bus_err_o=1, captured data forced to 0, go DONE.
- DONE: stall_o=0; load_valid_o=1 for loads only (not on timeout); go IDLE.
  - The pipeline advances on this cycle, so the request seen in the next IDLE cycle is a new instruction.
- stall_o = (IDLE & aligned request) | REQ | WAIT_RSP.
- Minimum latency for an aligned access: 3 cycles with stall (IDLE->REQ->WAIT_RSP->DONE). With ready and rsp in the same cycle: 2 cycles.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
- Write data: byte replicated ×4; half replicated ×2.
- Load extraction:
  - Select lane by latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Undefined funct3 (011, 110, 111) is treated as LW/SW.
- dbus_rsp_valid_i outside WAIT_RSP/REQ is ignored.

Decomposition:
- lsu_pkg:
  - funct3 constants (F3_LB..F3_LHU, F3_SB/SH/SW)
  - state enum lsu_state_e
  - be/size typedef
- Sub-module lsu_align (combinational): be and wdata generation, plus load extract/extend. Instantiated once and shared by both directions.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ready and rsp next cycle each:
  - dbus_addr=0x100, be=1111, we=1
  - stall high for 3 cycles, no load_valid
- LB addr=0x103, rdata=0x80FF_0000:
  - be=1000 on the request
  - load_data_o=0xFFFFFF80, load_valid pulse in DONE
- LHU addr=0x102, rdata=0xBEEF_1234:
  - be=1100
  - load_data_o=0x0000BEEF
- LW addr=0x101 → misaligned_o pulse, dbus_valid never asserts, stall_o=0.
- SH addr=0x2, ready held 0 for 5 cycles, then rsp:
  - valid, addr, be=1100 and wdata=0x56785678 (wdata_i=0x1234_5678) stable throughout
  - stall held for the whole wait
- TIMEOUT=4, LW with dbus_ready_i held 0:
  - bus_err_o pulse after 4 REQ cycles, no load_valid
  - returns to IDLE
  - rst asserted mid-WAIT_RSP drops all outputs to 0 asynchronously
